ddf_ms_pick_merge: RTL and testbench

- Multi-stream (FLUX tagged streams) dynamic-dataflow actor with two data input ports (port 0, port 1) and one control port (nda).
- Each port is a set of per-flux FIFOs, demultiplexed by the tag in the token MSBs.
- A per-flux control token selects the firing rule: pick port 0, pick port 1, or add both.
- One shared output port carries tagged results downstream, with back-pressure.

---
 rtl/ddf_ms_pick_merge.sv | 171 +++++++++++++++++
 tb/tb_ddf_ms_pick_merge.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ddf_ms_pick_merge.sv
// Multi-flux dynamic-dataflow pick/merge actor: per-flux FIFOs on two data ports and a control port.
// Build option DDF_MS_SAT_EN makes the mode-2/3 sum saturate instead of wrapping.
module ddf_ms_pick_merge #(
  parameter int WIDTH = 9,
  parameter int FLUX  = 2,
  parameter int PORTS = 2,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_port_write_fifo_0,
  input  logic [WIDTH-1:0]    in_port_datain_fifo_0,
  output logic [FLUX-1:0]     in_port_full_fifo_0,
  input  logic                in_port_write_fifo_1,
  input  logic [WIDTH-1:0]    in_port_datain_fifo_1,
  output logic [FLUX-1:0]     in_port_full_fifo_1,
  input  logic                in_port_write_fifo_nda,
  input  logic [WIDTH-1:0]    in_port_datain_fifo_nda,
  output logic [FLUX-1:0]     in_port_full_fifo_nda,
  input  logic                out_port_full,
  output logic                out_port_write,
  output logic [WIDTH-1:0]    out_port_dataout
);
  localparam int TW = $clog2(FLUX);
  localparam int DW = WIDTH - TW;
  localparam int AW = $clog2(DEPTH);
  localparam int NQ = PORTS + 1;
  localparam int QN = NQ - 1;
  localparam logic [AW:0] FULLCNT = (AW+1)'(DEPTH);

  logic [DW-1:0]   mem_q [NQ][FLUX][DEPTH];
  logic [AW-1:0]   wp_q  [NQ][FLUX];
  logic [AW-1:0]   rp_q  [NQ][FLUX];
  logic [AW:0]     cnt_q [NQ][FLUX];
  logic            wr    [NQ];
  logic [WIDTH-1:0] din  [NQ];
  logic            push  [NQ][FLUX];
  logic            pop   [NQ][FLUX];

  logic [1:0]      mode_q [FLUX];
  logic [FLUX-1:0] mv_q;
  logic [TW-1:0]   rr_q, rr_d;
  logic [FLUX-1:0] elig;
  logic            fire;
  logic [TW-1:0]   sel;
  logic [DW-1:0]   p0h, p1h, res;
  logic [DW:0]     sum;
  logic            fire_q;
  logic [TW-1:0]   ftag_q;
  logic [DW-1:0]   fres_q;

  assign wr[0]  = in_port_write_fifo_0;
  assign wr[1]  = in_port_write_fifo_1;
  assign wr[QN] = in_port_write_fifo_nda;
  assign din[0]  = in_port_datain_fifo_0;
  assign din[1]  = in_port_datain_fifo_1;
  assign din[QN] = in_port_datain_fifo_nda;

  always_comb begin
    for (int unsigned f = 0; f < FLUX; f++) begin
      in_port_full_fifo_0[f]   = (cnt_q[0][f]  == FULLCNT);
      in_port_full_fifo_1[f]   = (cnt_q[1][f]  == FULLCNT);
      in_port_full_fifo_nda[f] = (cnt_q[QN][f] == FULLCNT);
    end
  end

  // Tags >= FLUX match no queue, so such writes fall away like writes to a full queue.
  always_comb begin
    for (int unsigned q = 0; q < NQ; q++)
      for (int unsigned f = 0; f < FLUX; f++)
        push[q][f] = wr[q] && (din[q][WIDTH-1 -: TW] == TW'(f)) && (cnt_q[q][f] != FULLCNT);
  end

  always_comb begin
    elig = '0;
    for (int unsigned f = 0; f < FLUX; f++) begin
      case (mode_q[f])
        2'd0:    elig[f] = (cnt_q[0][f] != '0);
        2'd1:    elig[f] = (cnt_q[1][f] != '0);
        default: elig[f] = (cnt_q[0][f] != '0) && (cnt_q[1][f] != '0);
      endcase
      elig[f] = elig[f] && mv_q[f] && !out_port_full;
    end
  end

  always_comb begin
    int unsigned idx;
    idx  = 0;
    fire = 1'b0;
    sel  = '0;
    for (int unsigned i = 0; i < FLUX; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= FLUX) idx = idx - FLUX;
      if (!fire && elig[TW'(idx)]) begin
        fire = 1'b1;
        sel  = TW'(idx);
      end
    end

    p0h = mem_q[0][sel][rp_q[0][sel]];
    p1h = mem_q[1][sel][rp_q[1][sel]];
    sum = {1'b0, p0h} + {1'b0, p1h};
    case (mode_q[sel])
      2'd0:    res = p0h;
      2'd1:    res = p1h;
`ifdef DDF_MS_SAT_EN
      default: res = sum[DW] ? '1 : sum[DW-1:0];
`else
      default: res = sum[DW-1:0];
`endif
    endcase

    for (int unsigned q = 0; q < NQ; q++)
      for (int unsigned f = 0; f < FLUX; f++)
        pop[q][f] = 1'b0;
    for (int unsigned f = 0; f < FLUX; f++)
      pop[QN][f] = (cnt_q[QN][f] != '0);
    if (fire) begin
      pop[0][sel] = (mode_q[sel] != 2'd1);
      pop[1][sel] = (mode_q[sel] != 2'd0);
    end

    rr_d = rr_q;
    if (fire) rr_d = (sel == TW'(FLUX-1)) ? '0 : sel + 1'b1;
  end

  always_ff @(posedge clk) begin
    for (int unsigned q = 0; q < NQ; q++)
      for (int unsigned f = 0; f < FLUX; f++)
        if (push[q][f]) mem_q[q][f][wp_q[q][f]] <= din[q][DW-1:0];
  end

  // Firing reads mode_q before this edge's control load lands, so a same-cycle load never affects it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned q = 0; q < NQ; q++)
        for (int unsigned f = 0; f < FLUX; f++) begin
          wp_q[q][f]  <= '0;
          rp_q[q][f]  <= '0;
          cnt_q[q][f] <= '0;
        end
      for (int unsigned f = 0; f < FLUX; f++) mode_q[f] <= '0;
      mv_q             <= '0;
      rr_q             <= '0;
      fire_q           <= 1'b0;
      ftag_q           <= '0;
      fres_q           <= '0;
      out_port_write   <= 1'b0;
      out_port_dataout <= '0;
    end else begin
      for (int unsigned q = 0; q < NQ; q++)
        for (int unsigned f = 0; f < FLUX; f++) begin
          if (push[q][f]) wp_q[q][f] <= wp_q[q][f] + 1'b1;
          if (pop[q][f])  rp_q[q][f] <= rp_q[q][f] + 1'b1;
          if (push[q][f] && !pop[q][f])      cnt_q[q][f] <= cnt_q[q][f] + 1'b1;
          else if (!push[q][f] && pop[q][f]) cnt_q[q][f] <= cnt_q[q][f] - 1'b1;
        end
      for (int unsigned f = 0; f < FLUX; f++)
        if (pop[QN][f]) begin
          mode_q[f] <= mem_q[QN][f][rp_q[QN][f]][1:0];
          mv_q[f]   <= 1'b1;
        end
      rr_q           <= rr_d;
      fire_q         <= fire;
      ftag_q         <= sel;
      fres_q         <= res;
      out_port_write <= fire_q;
      if (fire_q) out_port_dataout <= {ftag_q, fres_q};
    end
  end
endmodule

// File: tb/tb_ddf_ms_pick_merge.sv
// Directed bench for ddf_ms_pick_merge (WIDTH=9, FLUX=2, DEPTH=4); outputs are logged and compared.
module tb_ddf_ms_pick_merge;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       w0, w1, wn;
  logic [8:0] d0, d1, dn;
  logic [1:0] full0, full1, fulln;
  logic       out_port_full;
  logic       out_port_write;
  logic [8:0] out_port_dataout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int base = 0;
  int w = 0;
  logic [8:0] obs_d[$];
  int         obs_t[$];

  ddf_ms_pick_merge #(.WIDTH(9), .FLUX(2), .PORTS(2), .DEPTH(4)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .in_port_write_fifo_0    (w0),
    .in_port_datain_fifo_0   (d0),
    .in_port_full_fifo_0     (full0),
    .in_port_write_fifo_1    (w1),
    .in_port_datain_fifo_1   (d1),
    .in_port_full_fifo_1     (full1),
    .in_port_write_fifo_nda  (wn),
    .in_port_datain_fifo_nda (dn),
    .in_port_full_fifo_nda   (fulln),
    .out_port_full           (out_port_full),
    .out_port_write          (out_port_write),
    .out_port_dataout        (out_port_dataout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (rst && out_port_write) begin
      obs_d.push_back(out_port_dataout);
      obs_t.push_back(cyc);
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic expo(input string tag, input int idx, input logic [8:0] exp);
    logic [31:0] got;
    got = (idx < obs_d.size()) ? {23'd0, obs_d[idx]} : 32'hDEAD_BEEF;
    chk(tag, got, {23'd0, exp});
  endtask

  task automatic clr();
    w0 = 1'b0; w1 = 1'b0; wn = 1'b0;
  endtask

  task automatic wr(input int p, input logic [8:0] d);
    case (p)
      0:       begin w0 = 1'b1; d0 = d; end
      1:       begin w1 = 1'b1; d1 = d; end
      default: begin wn = 1'b1; dn = d; end
    endcase
  endtask

  task automatic step();
    @(negedge clk);
    clr();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    clr();
    d0 = '0; d1 = '0; dn = '0;
    out_port_full = 1'b0;
    idle(3);
    chk("rst_write", out_port_write, 0);
    chk("rst_data", out_port_dataout, 0);
    chk("rst_full0", full0, 0);
    chk("rst_full1", full1, 0);
    chk("rst_fulln", fulln, 0);
    rst = 1'b1;
    idle(1);

    // no mode: queue fills at 4, 5th dropped
    for (int i = 1; i <= 5; i++) begin
      wr(0, {1'b0, 8'(i)});
      step();
      if (i <= 3) chk("nomode_full_pre", full0, 2'b00);
      else        chk("nomode_full_at", full0, 2'b01);
    end
    idle(3);
    chk("nomode_out", obs_d.size(), 0);
    wr(2, {1'b0, 8'd0});
    step();
    idle(8);
    chk("drain_cnt", obs_d.size(), 4);
    expo("drain0", 0, 9'h001);
    expo("drain1", 1, 9'h002);
    expo("drain2", 2, 9'h003);
    expo("drain3", 3, 9'h004);
    chk("drain_back2back", obs_t[3] - obs_t[0], 3);
    chk("drain_full", full0, 0);
    base = 4;

    // add mode, flux 0
    wr(2, {1'b0, 8'd2});
    step();
    idle(2);
    wr(0, {1'b0, 8'd3});
    wr(1, {1'b0, 8'd5});
    step();
    w = cyc;
    idle(5);
    chk("add_cnt", obs_d.size(), base + 1);
    expo("add_val", base, 9'h008);
    chk("add_latency", obs_t[base] - w, 2);
    chk("add_full0", full0, 0);
    chk("add_full1", full1, 0);
    base = 5;

    // pick port 1 on flux 1, sticky mode, port-0 token stays queued
    wr(2, {1'b1, 8'd1});
    wr(0, {1'b1, 8'h11});
    step();
    idle(2);
    wr(1, {1'b1, 8'd7});
    step();
    w = cyc;
    wr(1, {1'b1, 8'd9});
    step();
    idle(5);
    chk("pick_cnt", obs_d.size(), base + 2);
    expo("pick_a", base, 9'h107);
    expo("pick_b", base + 1, 9'h109);
    chk("pick_latency", obs_t[base] - w, 2);
    chk("pick_consec", obs_t[base + 1] - obs_t[base], 1);
    base = 7;
    wr(2, {1'b1, 8'd0});
    step();
    idle(4);
    chk("remode_cnt", obs_d.size(), base + 1);
    expo("remode_val", base, 9'h111);
    base = 8;

    // back-pressure
    out_port_full = 1'b1;
    wr(0, {1'b0, 8'd10});
    wr(1, {1'b0, 8'd20});
    step();
    wr(0, {1'b1, 8'd30});
    step();
    wr(0, {1'b1, 8'd31});
    step();
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold", out_port_write, 0);
      @(negedge clk);
    end
    chk("bp_none", obs_d.size(), base);
    out_port_full = 1'b0;
    idle(6);
    chk("bp_cnt", obs_d.size(), base + 3);
    expo("bp_a", base, 9'h01E);
    expo("bp_b", base + 1, 9'h11E);
    expo("bp_c", base + 2, 9'h11F);
    base = 11;

    // round-robin, both fluxes in mode 0
    out_port_full = 1'b1;
    wr(2, {1'b0, 8'd0});
    wr(0, {1'b0, 8'h41});
    step();
    wr(0, {1'b0, 8'h42});
    step();
    wr(0, {1'b1, 8'h51});
    step();
    wr(0, {1'b1, 8'h52});
    step();
    out_port_full = 1'b0;
    idle(8);
    chk("rr_cnt", obs_d.size(), base + 4);
    expo("rr0", base, 9'h041);
    expo("rr1", base + 1, 9'h151);
    expo("rr2", base + 2, 9'h042);
    expo("rr3", base + 3, 9'h152);
    base = 15;

    // add overflow
    wr(2, {1'b0, 8'd2});
    step();
    idle(2);
    wr(0, {1'b0, 8'd200});
    wr(1, {1'b0, 8'd100});
    step();
    idle(5);
    chk("ovf_cnt", obs_d.size(), base + 1);
`ifdef DDF_MS_SAT_EN
    expo("ovf_val", base, 9'h0FF);
`else
    expo("ovf_val", base, 9'h02C);
`endif
    base = 16;

    // async reset mid-stream
    out_port_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr(0, {1'b0, 8'(i + 1)});
      step();
    end
    chk("pre_rst_full", full0, 2'b01);
    wr(2, {1'b1, 8'd1});
    wr(1, {1'b1, 8'h33});
    step();
    #2 rst = 1'b0;
    #1;
    chk("arst_write", out_port_write, 0);
    chk("arst_data", out_port_dataout, 0);
    chk("arst_full0", full0, 0);
    chk("arst_full1", full1, 0);
    @(negedge clk);
    rst = 1'b1;
    out_port_full = 1'b0;
    idle(5);
    chk("arst_nomode", obs_d.size(), base);
    wr(2, {1'b0, 8'd0});
    step();
    idle(5);
    chk("arst_empty", obs_d.size(), base);
    wr(0, {1'b0, 8'h66});
    step();
    idle(5);
    chk("arst_resume_cnt", obs_d.size(), base + 1);
    expo("arst_resume", base, 9'h066);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
